// File: rtl/xor_stream_cipher.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | xor_stream_cipher                                                          |
// | Burst XOR cipher: static key, Galois-LFSR keystream or CFB, stream I/O.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module xor_stream_cipher #(
    parameter int                DATA_W    = 32,
    parameter int                LEN_W     = 8,
    parameter logic [DATA_W-1:0] LFSR_POLY = 32'h8020_0003
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              decrypt,
    input  logic [DATA_W-1:0] key_in,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] c_MODE_LFSR    = 2'd1;
    localparam logic [1:0] c_MODE_CFB     = 2'd2;
    localparam logic [1:0] c_MODE_ILLEGAL = 2'd3;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_key;
    logic [1:0]          r_mode;
    logic                r_decrypt;
    logic [LEN_W-1:0]    r_rem;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_last;
    logic                r_err;

    logic                w_accept;
    logic                w_launch;
    logic [DATA_W-1:0]   w_cipher;
    logic [DATA_W-1:0]   w_key_nxt;

    assign in_ready  = (r_state == S_RUN) && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_launch  = (r_state == S_IDLE) && start && (mode != c_MODE_ILLEGAL);
    assign w_cipher  = in_data ^ r_key;

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign err       = r_err;

    // In CFB the next key is always the ciphertext, whichever side of the XOR it is on.
    always_comb begin
        w_key_nxt = r_key;
        case (r_mode)
            c_MODE_LFSR: w_key_nxt = {1'b0, r_key[DATA_W-1:1]} ^ (r_key[0] ? LFSR_POLY : '0);
            c_MODE_CFB:  w_key_nxt = r_decrypt ? in_data : w_cipher;
            default:     w_key_nxt = r_key;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_launch) begin
                    w_state_nxt = (len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_accept && (r_rem == LEN_W'(1))) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_out_valid && out_ready) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_key       <= '0;
            r_mode      <= '0;
            r_decrypt   <= 1'b0;
            r_rem       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= (r_state == S_IDLE) && start && (mode == c_MODE_ILLEGAL);

            if (w_launch && (len != '0)) begin
                r_key     <= key_in;
                r_mode    <= mode;
                r_decrypt <= decrypt;
                r_rem     <= len;
            end

            // A new word overwrites the register even while the old one drains.
            if (w_accept) begin
                r_out_data  <= w_cipher;
                r_out_valid <= 1'b1;
                r_out_last  <= (r_rem == LEN_W'(1));
                r_rem       <= (r_rem != '0) ? r_rem - LEN_W'(1) : r_rem;
                r_key       <= w_key_nxt;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_xor_stream_cipher.sv
`default_nettype none
// Testbench for xor_stream_cipher: randomized bursts scored against a keystream model.
module tb_xor_stream_cipher;

    localparam logic [31:0] POLY = 32'h8020_0003;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic        decrypt;
    logic [31:0] key_in;
    logic [7:0]  len;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        err;

    int errors = 0;
    int checks = 0;

    logic [31:0] in_words [256];
    logic [31:0] got_q [$];

    always #5 clk = ~clk;

    xor_stream_cipher dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .decrypt   (decrypt),
        .key_in    (key_in),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // bp: 0 random out_ready, 1 full rate (always ready, input always valid), 2 one 3-cycle stall
    task automatic run_burst(input logic [1:0] m, input logic d, input logic [31:0] key,
                             input int n, input int bp, input bit poke);
        logic [31:0] exp_q [$];
        logic [31:0] kk, c, prev_data;
        int sent, rcvd, cyc, stall;
        bit prev_stall, fin, stall_used;
        exp_q.delete();
        got_q.delete();
        kk = key;
        for (int i = 0; i < n; i++) begin
            c = in_words[i] ^ kk;
            exp_q.push_back(c);
            if (m == 2'd1)      kk = (kk >> 1) ^ (kk[0] ? POLY : 32'h0);
            else if (m == 2'd2) kk = d ? in_words[i] : c;
        end
        start = 1'b1; mode = m; decrypt = d; key_in = key; len = 8'(n);
        @(negedge clk);
        start = 1'b0; key_in = $urandom; mode = 2'($urandom_range(0, 2));
        decrypt = 1'($urandom); len = 8'($urandom);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_latency: busy=%b in_ready=%b required 1/1", busy, in_ready);
        end
        sent = 0; rcvd = 0; cyc = 0; stall = 0;
        prev_stall = 0; fin = 0; stall_used = 0; prev_data = '0;
        while (!fin && cyc < 400) begin
            in_valid = (sent < n) && (bp == 1 || $urandom_range(0, 3) != 0);
            in_data  = (sent < n) ? in_words[sent] : $urandom;
            case (bp)
                0: out_ready = 1'($urandom_range(0, 1));
                1: out_ready = 1'b1;
                default: begin
                    if (!stall_used && rcvd >= 1 && out_valid) begin
                        stall = 3;
                        stall_used = 1;
                    end
                    out_ready = (stall == 0);
                    if (stall > 0) stall--;
                end
            endcase
            start = poke && ($urandom_range(0, 1) == 1);
            if (poke) begin
                mode = 2'($urandom);
                len  = 8'($urandom);
            end
            #1;
            checks++;
            if (err !== 1'b0) begin
                errors++;
                $display("FAIL no_err_in_burst: err=%b required 0", err);
            end
            if (out_valid && !out_ready) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_in_ready: in_ready=%b required 0", in_ready);
                end
            end
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    errors++;
                    $display("FAIL hold: out_valid=%b out_data=%h required 1 %h", out_valid, out_data, prev_data);
                end
            end
            if (done === 1'b1) begin
                fin = 1;
                checks++;
                if (rcvd != n) begin
                    errors++;
                    $display("FAIL word_count: got %0d words required %0d", rcvd, n);
                end
                if (bp == 1) begin
                    checks++;
                    if (cyc != n + 1) begin
                        errors++;
                        $display("FAIL throughput: done after %0d cycles required %0d", cyc, n + 1);
                    end
                end
            end else begin
                if (out_valid && out_ready) begin
                    checks++;
                    if (rcvd >= n) begin
                        errors++;
                        $display("FAIL extra_word: out_data=%h beyond %0d words", out_data, n);
                    end else if (out_data !== exp_q[rcvd] || out_last !== (rcvd == n - 1)) begin
                        errors++;
                        $display("FAIL data[%0d]: out_data=%h last=%b required %h last=%b",
                                 rcvd, out_data, out_last, exp_q[rcvd], (rcvd == n - 1));
                    end
                    got_q.push_back(out_data);
                    rcvd++;
                end
                if (in_valid && in_ready) sent++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; in_valid = 1'b0;
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL timeout: burst of %0d words did not finish, got %0d", n, rcvd);
        end else if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: done=%b busy=%b required 0/0", done, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 0; mode = 0; decrypt = 0; key_in = 0; len = 0;
        in_valid = 0; in_data = 0; out_ready = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({in_ready, out_valid, out_last, busy, done, err} !== 6'b0 || out_data !== 32'h0) begin
            errors++;
            $display("FAIL reset: flags=%b out_data=%h required 000000 00000000",
                     {in_ready, out_valid, out_last, busy, done, err}, out_data);
        end
    endtask

    task automatic test_static();
        in_words[0] = 32'hdeadbeef;
        in_words[1] = 32'h01234567;
        run_burst(2'd0, 1'b0, 32'h12345678, 2, 1, 0);
        checks++;
        if (got_q.size() != 2 || got_q[0] !== 32'hcc99e897 || got_q[1] !== 32'h1317131f) begin
            errors++;
            $display("FAIL static_vec: got %p required cc99e897 1317131f", got_q);
        end
    endtask

    task automatic test_lfsr();
        for (int i = 0; i < 3; i++) in_words[i] = 32'h0;
        run_burst(2'd1, 1'b0, 32'h00000001, 3, 0, 0);
        checks++;
        if (got_q.size() != 3 || got_q[0] !== 32'h00000001 || got_q[1] !== 32'h80200003
            || got_q[2] !== 32'hc0300002) begin
            errors++;
            $display("FAIL lfsr_vec: got %p required 00000001 80200003 c0300002", got_q);
        end
    endtask

    task automatic test_cfb();
        in_words[0] = 32'hdeadbeef;
        in_words[1] = 32'h01234567;
        run_burst(2'd2, 1'b0, 32'h12345678, 2, 0, 0);
        checks++;
        if (got_q.size() != 2 || got_q[0] !== 32'hcc99e897 || got_q[1] !== 32'hcdbaadf0) begin
            errors++;
            $display("FAIL cfb_enc: got %p required cc99e897 cdbaadf0", got_q);
        end
        in_words[0] = 32'hcc99e897;
        in_words[1] = 32'hcdbaadf0;
        run_burst(2'd2, 1'b1, 32'h12345678, 2, 0, 0);
        checks++;
        if (got_q.size() != 2 || got_q[0] !== 32'hdeadbeef || got_q[1] !== 32'h01234567) begin
            errors++;
            $display("FAIL cfb_dec: got %p required deadbeef 01234567", got_q);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 6; i++) in_words[i] = $urandom;
        run_burst(2'd1, 1'b0, $urandom, 6, 2, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) in_words[i] = $urandom;
        run_burst(2'd2, 1'b0, $urandom, 8, 1, 0);
        for (int i = 0; i < 5; i++) in_words[i] = $urandom;
        run_burst(2'd0, 1'b0, $urandom, 5, 1, 0);
    endtask

    task automatic test_errors();
        start = 1'b1; mode = 2'd3; len = 8'd5; key_in = $urandom;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse: err=%b busy=%b in_ready=%b required 1/0/0", err, busy, in_ready);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: err=%b busy=%b required 0/0", err, busy);
        end
        start = 1'b1; mode = 2'd0; len = 8'd0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL len0_done: done=%b busy=%b out_valid=%b in_ready=%b required 1/1/0/0",
                     done, busy, out_valid, in_ready);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL len0_idle: done=%b busy=%b required 0/0", done, busy);
        end
    endtask

    task automatic test_random();
        int n;
        logic [1:0] m;
        for (int b = 0; b < 6; b++) begin
            n = $urandom_range(1, 20);
            m = 2'($urandom_range(0, 2));
            for (int i = 0; i < n; i++) in_words[i] = $urandom;
            run_burst(m, 1'($urandom), $urandom, n, 0, 1);
        end
    endtask

    task automatic test_reset_mid_burst();
        int dones = 0;
        start = 1'b1; mode = 2'd1; len = 8'd5; key_in = $urandom; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = $urandom;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({in_ready, out_valid, out_last, busy, done, err} !== 6'b0 || out_data !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset: flags=%b out_data=%h required 000000 00000000",
                     {in_ready, out_valid, out_last, busy, done, err}, out_data);
        end
        repeat (4) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        checks++;
        if (dones != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_done: done pulses=%0d busy=%b required 0/0", dones, busy);
        end
        for (int i = 0; i < 4; i++) in_words[i] = $urandom;
        run_burst(2'd0, 1'b0, $urandom, 4, 0, 0);
    endtask

    initial begin
        test_reset();
        test_static();
        test_lfsr();
        test_cfb();
        test_backpressure();
        test_back_to_back();
        test_errors();
        test_random();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
